mem_stage: RTL

Memory-access stage of the pipelined LC-3b core. Sits directly downstream of the EX/MEM pipeline register (ir3): accepts one instruction at a time, performs LDR/LDB/STR/STB/LDI/STI on the data-memory port with a request/response handshake, and stalls upstream until the access completes. Non-memory instructions pass through in one cycle. Its registered outputs form the MEM/WB pipeline register feeding register-file writeback.

---
 rtl/mem_stage_if.sv | 28 ++
 rtl/mem_stage.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage_if.sv
// mem_stage_if: data-memory port of the LC-3b MEM stage.
//   mem_address     16  word/byte address of the current request
//   mem_wdata       16  store data
//   mem_rdata       16  load data returned by memory
//   mem_read        1   read request strobe
//   mem_write       1   write request strobe
//   mem_byte_enable 2   [1] high byte, [0] low byte
//   mem_resp        1   one-cycle completion pulse from memory
// master = pipeline stage (issues requests), slave = memory model/controller.
interface mem_stage_if;
  logic [15:0] mem_address;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata;
  logic        mem_read;
  logic        mem_write;
  logic [1:0]  mem_byte_enable;
  logic        mem_resp;

  modport master (
    output mem_address, mem_wdata, mem_read, mem_write, mem_byte_enable,
    input  mem_rdata, mem_resp
  );

  modport slave (
    input  mem_address, mem_wdata, mem_read, mem_write, mem_byte_enable,
    output mem_rdata, mem_resp
  );
endinterface

// File: rtl/mem_stage.sv
// mem_stage: memory-access stage of the pipelined LC-3b core.
// Accepts one instruction from ir3, performs LDR/LDB/STR/STB/LDI/STI through
// the data-memory handshake, stalls upstream until the access completes, and
// drives the MEM/WB pipeline register.
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   in_valid/in_op        ir3 valid and memory opcode (0 NONE..6 STI, 7 = NONE)
//   in_address/in_wdata   effective address and store data
//   in_aluresult          pass-through result for non-memory ops
//   in_drid/in_ld_reg/in_ld_cc  writeback destination and enables
//   mem                   data-memory port (mem_stage_if.master)
//   stall                 hold ir3 and everything upstream
//   wb_valid/wb_data/wb_drid/wb_ld_reg/wb_ld_cc  MEM/WB register
module mem_stage (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [2:0]        in_op,
  input  logic [15:0]       in_address,
  input  logic [15:0]       in_wdata,
  input  logic [15:0]       in_aluresult,
  input  logic [2:0]        in_drid,
  input  logic              in_ld_reg,
  input  logic              in_ld_cc,
  mem_stage_if.master       mem,
  output logic              stall,
  output logic              wb_valid,
  output logic [15:0]       wb_data,
  output logic [2:0]        wb_drid,
  output logic              wb_ld_reg,
  output logic              wb_ld_cc
);

  localparam logic [2:0] OP_NONE = 3'd0;
  localparam logic [2:0] OP_LDR  = 3'd1;
  localparam logic [2:0] OP_LDB  = 3'd2;
  localparam logic [2:0] OP_STR  = 3'd3;
  localparam logic [2:0] OP_STB  = 3'd4;
  localparam logic [2:0] OP_LDI  = 3'd5;
  localparam logic [2:0] OP_STI  = 3'd6;
  localparam logic [2:0] OP_NOP7 = 3'd7;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    IND   = 2'd1,
    FINAL = 2'd2
  } state_t;

  state_t      state_r, next_state_s;
  logic [2:0]  op_r;
  logic [15:0] addr_r;
  logic [15:0] wdata_r;
  logic [2:0]  drid_r;
  logic        ld_reg_r;
  logic        ld_cc_r;

  logic        is_memop_s;
  logic        stall_s;
  logic        read_s;
  logic        write_s;
  logic [1:0]  be_s;
  logic [15:0] maddr_s;
  logic [15:0] mwdata_s;
  logic [15:0] load_s;
  logic [7:0]  byte_s;

  // Opcode 7 behaves exactly like NONE.
  assign is_memop_s = (in_op != OP_NONE) && (in_op != OP_NOP7);

  // Next-state, stall and memory-request decode from state and latched fields.
  always_comb begin
    next_state_s = state_r;
    stall_s      = 1'b0;
    read_s       = 1'b0;
    write_s      = 1'b0;
    be_s         = 2'b00;
    maddr_s      = 16'h0000;
    mwdata_s     = 16'h0000;
    load_s       = 16'h0000;
    // addr[0] = 1 selects the high byte for LDB.
    byte_s       = addr_r[0] ? mem.mem_rdata[15:8] : mem.mem_rdata[7:0];
    case (state_r)
      IDLE: begin
        if (in_valid && is_memop_s) begin
          stall_s      = 1'b1;
          next_state_s = ((in_op == OP_LDI) || (in_op == OP_STI)) ? IND : FINAL;
        end else begin
          next_state_s = IDLE;
        end
      end
      IND: begin
        stall_s = 1'b1;
        read_s  = 1'b1;
        be_s    = 2'b11;
        maddr_s = {addr_r[15:1], 1'b0};
        if (mem.mem_resp) begin
          next_state_s = FINAL;
        end else begin
          next_state_s = IND;
        end
      end
      FINAL: begin
        // Stall drops in the response cycle so ir3 advances on that edge.
        stall_s      = ~mem.mem_resp;
        next_state_s = mem.mem_resp ? IDLE : FINAL;
        maddr_s      = {addr_r[15:1], 1'b0};
        case (op_r)
          OP_LDR, OP_LDI: begin
            read_s = 1'b1;
            be_s   = 2'b11;
            load_s = mem.mem_rdata;
          end
          OP_LDB: begin
            read_s = 1'b1;
            be_s   = 2'b11;
            load_s = {{8{byte_s[7]}}, byte_s};
          end
          OP_STR, OP_STI: begin
            write_s  = 1'b1;
            be_s     = 2'b11;
            mwdata_s = wdata_r;
            load_s   = wdata_r;
          end
          OP_STB: begin
            write_s  = 1'b1;
            be_s     = addr_r[0] ? 2'b10 : 2'b01;
            mwdata_s = {wdata_r[7:0], wdata_r[7:0]};
            load_s   = wdata_r;
          end
          default: begin
            load_s = wdata_r;
          end
        endcase
      end
      default: begin
        next_state_s = IDLE;
      end
    endcase
  end

  assign stall               = stall_s;
  assign mem.mem_read        = read_s;
  assign mem.mem_write       = write_s;
  assign mem.mem_byte_enable = be_s;
  assign mem.mem_address     = maddr_s;
  assign mem.mem_wdata       = mwdata_s;

  // State register, latched instruction fields and MEM/WB register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r   <= IDLE;
      op_r      <= 3'd0;
      addr_r    <= 16'h0000;
      wdata_r   <= 16'h0000;
      drid_r    <= 3'd0;
      ld_reg_r  <= 1'b0;
      ld_cc_r   <= 1'b0;
      wb_valid  <= 1'b0;
      wb_data   <= 16'h0000;
      wb_drid   <= 3'd0;
      wb_ld_reg <= 1'b0;
      wb_ld_cc  <= 1'b0;
    end else begin
      state_r  <= next_state_s;
      wb_valid <= 1'b0;
      case (state_r)
        IDLE: begin
          if (in_valid && !is_memop_s) begin
            wb_valid  <= 1'b1;
            wb_data   <= in_aluresult;
            wb_drid   <= in_drid;
            wb_ld_reg <= in_ld_reg;
            wb_ld_cc  <= in_ld_cc;
          end else if (in_valid) begin
            op_r     <= in_op;
            addr_r   <= in_address;
            wdata_r  <= in_wdata;
            drid_r   <= in_drid;
            ld_reg_r <= in_ld_reg;
            ld_cc_r  <= in_ld_cc;
          end
        end
        IND: begin
          // Pointer read: the returned word becomes the data address.
          if (mem.mem_resp) begin
            addr_r <= mem.mem_rdata;
          end
        end
        FINAL: begin
          if (mem.mem_resp) begin
            wb_valid  <= 1'b1;
            wb_data   <= load_s;
            wb_drid   <= drid_r;
            wb_ld_reg <= ld_reg_r;
            wb_ld_cc  <= ld_cc_r;
          end
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule
